// File: rtl/gemv_tile_if.sv
// Stream and control bundle between the GeMV tile engine and its host/writeback.
// The host drives the master side; the engine takes the slave side.
interface gemv_tile_if #(
   parameter int IW      = 8,
   parameter int WW      = 8,
   parameter int OW      = 32,
   parameter int VEC_LEN = 8,
   parameter int ROWS    = 32,
   parameter int NUM_PE  = 4,
   parameter int CHUNK_W = 16
);
   logic                            start;
   logic                            abort;
   logic [CHUNK_W-1:0]              cfg_num_chunks;
   logic                            cfg_signed;
   logic [NUM_PE-1:0]               cfg_pe_mask;
   logic                            in_valid;
   logic                            in_ready;
   logic [VEC_LEN*IW-1:0]           in_vec;
   logic [NUM_PE*ROWS*VEC_LEN*WW-1:0] in_wgt;
   logic                            out_valid;
   logic                            out_ready;
   logic [NUM_PE*OW-1:0]            out_data;
   logic [$clog2(ROWS)-1:0]         out_row;
   logic                            out_last;
   logic                            busy;
   logic                            done;
   logic                            sat_flag;

   modport master (
      output start, abort, cfg_num_chunks, cfg_signed, cfg_pe_mask,
      output in_valid, in_vec, in_wgt, out_ready,
      input  in_ready, out_valid, out_data, out_row, out_last, busy, done, sat_flag
   );

   modport slave (
      input  start, abort, cfg_num_chunks, cfg_signed, cfg_pe_mask,
      input  in_valid, in_vec, in_wgt, out_ready,
      output in_ready, out_valid, out_data, out_row, out_last, busy, done, sat_flag
   );
endinterface

// File: rtl/gemv_tile_engine.sv
// NUM_PE-lane GeMV tile: broadcast input chunks, per-lane ROWS x VEC_LEN weights,
// saturating accumulation over a programmable chunk count, then a row-by-row drain.
module gemv_tile_engine #(
   parameter int IW      = 8,
   parameter int WW      = 8,
   parameter int OW      = 32,
   parameter int VEC_LEN = 8,
   parameter int ROWS    = 32,
   parameter int NUM_PE  = 4,
   parameter int CHUNK_W = 16
) (
   input logic        clk,
   input logic        rst_n,
   gemv_tile_if.slave io
);
   localparam int RW = $clog2(ROWS);
   localparam int DW = IW + WW + $clog2(VEC_LEN) + 1;
   // Sum width covers both the accumulator and an exact dot product, so narrow OW still clamps correctly.
   localparam int SW = ((OW > DW) ? OW : DW) + 1;
   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
   localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t             state_reg;
   logic [CHUNK_W-1:0] num_chunks_reg;
   logic [CHUNK_W-1:0] chunk_cnt_reg;
   logic               signed_reg;
   logic [NUM_PE-1:0]  mask_reg;
   logic [RW-1:0]      row_reg;
   logic               sat_reg;

   logic                   start_ok;
   logic                   beat;
   logic [NUM_PE*ROWS-1:0] sat_hit;
   logic signed [OW-1:0]   acc_arr [NUM_PE][ROWS];
   logic [NUM_PE*OW-1:0]   out_data_next;

   assign start_ok = (state_reg == IDLE) && io.start && (io.cfg_num_chunks != '0);
   assign beat     = (state_reg == LOAD) && io.in_valid;

   genvar gi, gr;
   generate
      for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
         for (gr = 0; gr < ROWS; gr++) begin : g_row
            logic signed [OW-1:0] acc_reg;
            logic signed [DW-1:0] dot;
            logic signed [DW-1:0] xe;
            logic signed [DW-1:0] we;
            logic [IW-1:0]        xs;
            logic [WW-1:0]        ws;
            logic signed [SW-1:0] sum;
            logic                 over_hi;
            logic                 over_lo;

            always_comb begin
               dot = '0;
               xe  = '0;
               we  = '0;
               xs  = '0;
               ws  = '0;
               for (int j = 0; j < VEC_LEN; j++) begin
                  xs  = io.in_vec[j*IW +: IW];
                  ws  = io.in_wgt[((gi*ROWS + gr)*VEC_LEN + j)*WW +: WW];
                  xe  = {{(DW-IW){signed_reg & xs[IW-1]}}, xs};
                  we  = {{(DW-WW){signed_reg & ws[WW-1]}}, ws};
                  dot = dot + xe * we;
               end
               sum = {{(SW-OW){acc_reg[OW-1]}}, acc_reg} + {{(SW-DW){dot[DW-1]}}, dot};
            end

            assign over_hi = (sum > SAT_MAX);
            assign over_lo = (sum < SAT_MIN);
            assign sat_hit[gi*ROWS + gr] = beat & mask_reg[gi] & (over_hi | over_lo);
            assign acc_arr[gi][gr] = acc_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  acc_reg <= '0;
               end else if (io.abort || start_ok) begin
                  acc_reg <= '0;
               end else if (beat && mask_reg[gi]) begin
                  acc_reg <= over_hi ? OUT_MAX : (over_lo ? OUT_MIN : sum[OW-1:0]);
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         num_chunks_reg <= '0;
         chunk_cnt_reg  <= '0;
         signed_reg     <= 1'b0;
         mask_reg       <= '0;
         row_reg        <= '0;
         sat_reg        <= 1'b0;
      end else if (io.abort) begin
         state_reg     <= IDLE;
         chunk_cnt_reg <= '0;
         row_reg       <= '0;
      end else begin
         case (state_reg)
            IDLE: if (start_ok) begin
               state_reg      <= LOAD;
               num_chunks_reg <= io.cfg_num_chunks;
               signed_reg     <= io.cfg_signed;
               mask_reg       <= io.cfg_pe_mask;
               chunk_cnt_reg  <= '0;
               row_reg        <= '0;
               sat_reg        <= 1'b0;
            end
            LOAD: if (io.in_valid) begin
               chunk_cnt_reg <= chunk_cnt_reg + CHUNK_W'(1);
               if (|sat_hit) sat_reg <= 1'b1;
               if (chunk_cnt_reg == num_chunks_reg - CHUNK_W'(1)) state_reg <= DRAIN;
            end
            DRAIN: if (io.out_ready) begin
               if (row_reg == RW'(ROWS-1)) begin
                  state_reg <= DONE;
                  row_reg   <= '0;
               end else begin
                  row_reg <= row_reg + RW'(1);
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Stream data is zeroed outside DRAIN so nothing stale appears on the bus.
   always_comb begin
      out_data_next = '0;
      if (state_reg == DRAIN) begin
         for (int p = 0; p < NUM_PE; p++) begin
            out_data_next[p*OW +: OW] = acc_arr[p][row_reg];
         end
      end
   end

   assign io.in_ready  = (state_reg == LOAD);
   assign io.out_valid = (state_reg == DRAIN);
   assign io.out_data  = out_data_next;
   assign io.out_row   = row_reg;
   assign io.out_last  = (state_reg == DRAIN) && (row_reg == RW'(ROWS-1));
   assign io.busy      = (state_reg != IDLE);
   assign io.done      = (state_reg == DONE);
   assign io.sat_flag  = sat_reg;
endmodule

// File: tb/tb_gemv_tile_engine.sv
// Randomised bench for gemv_tile_engine against an arithmetic reference model;
// a second OW=16 instance exercises saturation.
module tb_gemv_tile_engine;
   localparam int IW = 8, WW = 8, OW = 32, VL = 8, ROWS = 32, NP = 4, CW = 16, SOW = 16;
   localparam int WBITS = NP*ROWS*VL*WW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gemv_tile_if #(.IW(IW), .WW(WW), .OW(OW),  .VEC_LEN(VL), .ROWS(ROWS), .NUM_PE(NP), .CHUNK_W(CW)) bus ();
   gemv_tile_if #(.IW(IW), .WW(WW), .OW(SOW), .VEC_LEN(VL), .ROWS(ROWS), .NUM_PE(NP), .CHUNK_W(CW)) sbus ();

   gemv_tile_engine #(.IW(IW), .WW(WW), .OW(OW), .VEC_LEN(VL), .ROWS(ROWS), .NUM_PE(NP), .CHUNK_W(CW))
      dut (.clk(clk), .rst_n(rst_n), .io(bus));
   gemv_tile_engine #(.IW(IW), .WW(WW), .OW(SOW), .VEC_LEN(VL), .ROWS(ROWS), .NUM_PE(NP), .CHUNK_W(CW))
      dut_s (.clk(clk), .rst_n(rst_n), .io(sbus));

   int checks = 0;
   int errors = 0;

   longint exp_acc [NP][ROWS];
   bit     exp_sat;
   logic [VL*IW-1:0] cur_vec;
   logic [WBITS-1:0] cur_wgt;

   logic [NP*OW-1:0] cap_data [ROWS];
   int               cap_row  [ROWS];
   bit               cap_last [ROWS];
   int               cap_n, hold_bad, done_delay;
   bit               cap_timeout, load_timeout;

   function automatic longint elem(input logic [7:0] v, input bit sgn);
      if (sgn) return longint'($signed(v));
      return longint'(v);
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++)
         for (int r = 0; r < ROWS; r++) exp_acc[p][r] = 0;
      exp_sat = 0;
   endtask

   // acc = clamp(acc + exact dot product) for every enabled lane/row.
   task automatic model_beat(input bit sgn, input logic [NP-1:0] mask, input int ow);
      longint hi, lo, s;
      hi = (longint'(1) <<< (ow-1)) - 1;
      lo = -(longint'(1) <<< (ow-1));
      for (int p = 0; p < NP; p++) begin
         if (mask[p]) begin
            for (int r = 0; r < ROWS; r++) begin
               s = exp_acc[p][r];
               for (int j = 0; j < VL; j++)
                  s += elem(cur_vec[j*IW +: IW], sgn) * elem(cur_wgt[((p*ROWS + r)*VL + j)*WW +: WW], sgn);
               if (s > hi) begin s = hi; exp_sat = 1; end
               if (s < lo) begin s = lo; exp_sat = 1; end
               exp_acc[p][r] = s;
            end
         end
      end
   endtask

   task automatic fill_data(input bit rnd, input logic [7:0] xv, input logic [7:0] wv);
      for (int j = 0; j < VL; j++) cur_vec[j*IW +: IW] = rnd ? 8'($urandom) : xv;
      for (int k = 0; k < WBITS/8; k++) cur_wgt[k*8 +: 8] = rnd ? 8'($urandom) : wv;
   endtask

   task automatic scramble_cfg();
      bus.cfg_signed     = 1'($urandom);
      bus.cfg_pe_mask    = NP'($urandom);
      bus.cfg_num_chunks = CW'($urandom);
      bus.start          = 1'($urandom);
   endtask

   task automatic start_run(input int n, input bit sgn, input logic [NP-1:0] mask);
      bus.cfg_num_chunks = CW'(n);
      bus.cfg_signed     = sgn;
      bus.cfg_pe_mask    = mask;
      bus.start          = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      model_reset();
   endtask

   // Config pins and start are scrambled during LOAD; the engine must ignore them.
   task automatic send_beats(input int n, input bit sgn, input logic [NP-1:0] mask, input bit rnd,
                             input logic [7:0] xv, input logic [7:0] wv, input int gap_max);
      int guard;
      for (int b = 0; b < n; b++) begin
         repeat ($urandom_range(gap_max, 0)) begin
            bus.in_valid = 1'b0;
            scramble_cfg();
            @(negedge clk);
         end
         fill_data(rnd, xv, wv);
         bus.in_vec   = cur_vec;
         bus.in_wgt   = cur_wgt;
         bus.in_valid = 1'b1;
         scramble_cfg();
         guard = 0;
         while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
         if (guard >= 20) load_timeout = 1;
         model_beat(sgn, mask, OW);
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.start    = 1'b0;
      end
   endtask

   // rmode: 0 always ready, 1 pattern 1-0-0-1, 2 random.
   task automatic capture_drain(input int rmode);
      int cyc, last_hs, prev_row;
      bit prev_stall, done_seen;
      logic [NP*OW-1:0] prev_data;
      cyc = 0; last_hs = -10; prev_row = 0; prev_stall = 0; done_seen = 0; prev_data = '0;
      cap_n = 0; hold_bad = 0; done_delay = -1;
      while (!done_seen && cyc < 400) begin
         bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom);
         if (bus.done) begin done_seen = 1; done_delay = cyc - last_hs; end
         if (bus.out_valid) begin
            if (prev_stall && (bus.out_data !== prev_data || int'(bus.out_row) != prev_row)) hold_bad++;
            if (bus.out_ready) begin
               if (cap_n < ROWS) begin
                  cap_data[cap_n] = bus.out_data;
                  cap_row[cap_n]  = int'(bus.out_row);
                  cap_last[cap_n] = bus.out_last;
               end
               cap_n++;
               last_hs = cyc;
            end
            prev_stall = !bus.out_ready;
            prev_data  = bus.out_data;
            prev_row   = int'(bus.out_row);
         end else begin
            prev_stall = 0;
         end
         @(negedge clk);
         cyc++;
      end
      cap_timeout   = !done_seen;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.sat_flag} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=000000", {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.sat_flag});
      end
      checks++;
      if (bus.out_row !== '0 || bus.out_data !== '0) begin
         errors++;
         $display("FAIL reset_data row=%0d data=%h want 0", bus.out_row, bus.out_data);
      end
      checks++;
      if (sbus.busy !== 1'b0 || sbus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_sat_inst busy=%b out_valid=%b want 0", sbus.busy, sbus.out_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_gemv_run(input string name, input int n, input bit sgn, input logic [NP-1:0] mask,
                                input bit rnd, input logic [7:0] xv, input logic [7:0] wv,
                                input int gap, input int rmode);
      logic [NP*OW-1:0] ev;
      load_timeout = 0;
      start_run(n, sgn, mask);
      send_beats(n, sgn, mask, rnd, xv, wv, gap);
      checks++;
      if (load_timeout || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s/enter_drain timeout=%0d out_valid=%b in_ready=%b want 0/1/0", name, load_timeout, bus.out_valid, bus.in_ready);
      end
      capture_drain(rmode);
      checks++;
      if (cap_timeout || cap_n != ROWS) begin
         errors++;
         $display("FAIL %s/row_count got=%0d timeout=%0d want %0d", name, cap_n, cap_timeout, ROWS);
      end
      checks++;
      if (hold_bad != 0) begin
         errors++;
         $display("FAIL %s/hold got=%0d changes under stall want 0", name, hold_bad);
      end
      checks++;
      if (done_delay != 1) begin
         errors++;
         $display("FAIL %s/done_timing got=%0d want 1", name, done_delay);
      end
      for (int k = 0; k < ROWS && k < cap_n; k++) begin
         for (int p = 0; p < NP; p++) ev[p*OW +: OW] = exp_acc[p][k][OW-1:0];
         checks++;
         if (cap_data[k] !== ev || cap_row[k] != k || cap_last[k] != (k == ROWS-1)) begin
            errors++;
            $display("FAIL %s/row%0d got row=%0d last=%0d data=%h want row=%0d last=%0d data=%h",
                     name, k, cap_row[k], cap_last[k], cap_data[k], k, (k == ROWS-1), ev);
         end
      end
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sat_flag !== exp_sat) begin
         errors++;
         $display("FAIL %s/post_done done=%b busy=%b sat=%b want 0/0/%0d", name, bus.done, bus.busy, bus.sat_flag, exp_sat);
      end
      $display("run %s: chunks=%0d signed=%0d mask=%b ready_mode=%0d rows=%0d", name, n, sgn, mask, rmode, cap_n);
   endtask

   task automatic test_single_unsigned();
      test_gemv_run("single_u", 1, 1'b0, 4'hF, 1'b0, 8'd1, 8'd1, 0, 0);
      checks++;
      if (cap_data[5][2*OW +: OW] !== 32'd8) begin
         errors++;
         $display("FAIL single_u/value got=%0d want 8", cap_data[5][2*OW +: OW]);
      end
   endtask

   task automatic test_signed_multi();
      test_gemv_run("signed_multi", 3, 1'b1, 4'hF, 1'b0, 8'hFE, 8'h03, 3, 0);
      checks++;
      if (cap_data[31][3*OW +: OW] !== 32'hFFFFFF70) begin
         errors++;
         $display("FAIL signed_multi/value got=%h want ffffff70", cap_data[31][3*OW +: OW]);
      end
   endtask

   task automatic test_mode_switch();
      test_gemv_run("mode_u", 1, 1'b0, 4'hF, 1'b0, 8'hFF, 8'hFF, 1, 0);
      checks++;
      if (cap_data[0][0 +: OW] !== 32'd520200) begin
         errors++;
         $display("FAIL mode_u/value got=%0d want 520200", cap_data[0][0 +: OW]);
      end
      test_gemv_run("mode_s", 1, 1'b1, 4'hF, 1'b0, 8'hFF, 8'hFF, 1, 0);
      checks++;
      if (cap_data[0][0 +: OW] !== 32'd8) begin
         errors++;
         $display("FAIL mode_s/value got=%0d want 8", cap_data[0][0 +: OW]);
      end
   endtask

   task automatic test_mask_backpressure();
      int nz;
      test_gemv_run("mask_bp", 2, 1'($urandom), 4'b0101, 1'b1, 8'd0, 8'd0, 2, 1);
      nz = 0;
      for (int k = 0; k < ROWS; k++)
         if (cap_data[k][1*OW +: OW] !== '0 || cap_data[k][3*OW +: OW] !== '0) nz++;
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL mask_bp/masked_lanes got=%0d nonzero rows want 0", nz);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++)
         test_gemv_run($sformatf("random%0d", i), $urandom_range(4, 1), 1'($urandom), NP'($urandom),
                       1'b1, 8'd0, 8'd0, $urandom_range(2, 0), $urandom_range(2, 0));
   endtask

   task automatic test_saturation();
      int k, guard;
      logic [NP*SOW-1:0] ev;
      sbus.cfg_num_chunks = CW'(1);
      sbus.cfg_signed     = 1'b1;
      sbus.cfg_pe_mask    = 4'hF;
      sbus.start          = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      model_reset();
      fill_data(1'b0, 8'd127, 8'd127);
      sbus.in_vec   = cur_vec;
      sbus.in_wgt   = cur_wgt;
      sbus.in_valid = 1'b1;
      guard = 0;
      while (!sbus.in_ready && guard < 20) begin @(negedge clk); guard++; end
      model_beat(1'b1, 4'hF, SOW);
      @(negedge clk);
      sbus.in_valid  = 1'b0;
      sbus.out_ready = 1'b1;
      k = 0; guard = 0;
      while (k < ROWS && guard < 100) begin
         if (sbus.out_valid) begin
            for (int p = 0; p < NP; p++) ev[p*SOW +: SOW] = exp_acc[p][k][SOW-1:0];
            checks++;
            if (sbus.out_data !== ev || int'(sbus.out_row) != k) begin
               errors++;
               $display("FAIL sat/row%0d got row=%0d data=%h want row=%0d data=%h", k, sbus.out_row, sbus.out_data, k, ev);
            end
            if (k == 0) begin
               checks++;
               if (sbus.out_data[0 +: SOW] !== 16'h7FFF) begin
                  errors++;
                  $display("FAIL sat/clamp got=%h want 7fff", sbus.out_data[0 +: SOW]);
               end
            end
            k++;
         end
         @(negedge clk);
         guard++;
      end
      sbus.out_ready = 1'b0;
      checks++;
      if (k != ROWS) begin
         errors++;
         $display("FAIL sat/row_count got=%0d want %0d", k, ROWS);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (sbus.sat_flag !== exp_sat || sbus.busy !== 1'b0) begin
         errors++;
         $display("FAIL sat/flag got sat=%b busy=%b want %0d/0", sbus.sat_flag, sbus.busy, exp_sat);
      end
      sbus.start = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      checks++;
      if (sbus.sat_flag !== 1'b0 || sbus.busy !== 1'b1) begin
         errors++;
         $display("FAIL sat/restart_clear got sat=%b busy=%b want 0/1", sbus.sat_flag, sbus.busy);
      end
      sbus.abort = 1'b1;
      @(negedge clk);
      sbus.abort = 1'b0;
      $display("run saturation: rows=%0d sat_flag_expected=%0d", k, exp_sat);
   endtask

   task automatic test_abort();
      int dones;
      start_run(4, 1'b0, 4'hF);
      send_beats(1, 1'b0, 4'hF, 1'b1, 8'd0, 8'd0, 0);
      bus.abort = 1'b1; bus.in_valid = 1'b1; bus.start = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_load/idle busy=%b in_ready=%b want 0/0", bus.busy, bus.in_ready);
      end
      dones = 0;
      repeat (3) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL abort_load/no_done got=%0d pulses want 0", dones);
      end
      $display("run abort_load: aborted after 1 of 4 chunks");
      test_gemv_run("after_abort", 2, 1'($urandom), 4'hF, 1'b1, 8'd0, 8'd0, 1, 0);
      start_run(1, 1'b0, 4'hF);
      send_beats(1, 1'b0, 4'hF, 1'b1, 8'd0, 8'd0, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_drain got out_valid=%b busy=%b done=%b want 0/0/0", bus.out_valid, bus.busy, bus.done);
      end
      $display("run abort_drain: aborted during drain");
   endtask

   task automatic test_reset_mid_drain();
      start_run(2, 1'b1, 4'hF);
      send_beats(2, 1'b1, 4'hF, 1'b1, 8'd0, 8'd0, 0);
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== '0 || bus.out_row !== '0) begin
         errors++;
         $display("FAIL reset_mid_drain got out_valid=%b busy=%b row=%0d want 0/0/0", bus.out_valid, bus.busy, bus.out_row);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      $display("run reset_mid_drain: reset pulsed during drain");
   endtask

   task automatic test_start_zero();
      int dones;
      bus.cfg_num_chunks = '0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      repeat (2) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      checks++;
      if (bus.busy !== 1'b0 || dones != 0) begin
         errors++;
         $display("FAIL start_zero got busy=%b dones=%0d want 0/0", bus.busy, dones);
      end
      $display("run start_zero: start with zero chunks");
   endtask

   initial begin
      bus.start = 0; bus.abort = 0; bus.cfg_num_chunks = '0; bus.cfg_signed = 0; bus.cfg_pe_mask = '0;
      bus.in_valid = 0; bus.in_vec = '0; bus.in_wgt = '0; bus.out_ready = 0;
      sbus.start = 0; sbus.abort = 0; sbus.cfg_num_chunks = '0; sbus.cfg_signed = 0; sbus.cfg_pe_mask = '0;
      sbus.in_valid = 0; sbus.in_vec = '0; sbus.in_wgt = '0; sbus.out_ready = 0;
      test_reset();
      test_single_unsigned();
      test_signed_multi();
      test_mode_switch();
      test_saturation();
      test_mask_backpressure();
      test_random();
      test_abort();
      test_reset_mid_drain();
      test_start_zero();
      test_single_unsigned();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
